pipeline_stall_controller: RTL
==============================

Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage pipeline's stall, freeze and flush enables.
- Merges three sources into one consistent set of per-stage write and flush strobes:
  - the load-use stall request from the hazard detection unit;
  - the taken-branch signal from EX;
  - a multi-cycle data-memory handshake.
- Adds a memory-wait timeout with a sticky error flag, and saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before error; 0 disables the timeout.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_use_stall  in  1  load-use hazard from hazard detection (ID instruction depends on a load in EX)
- branch_taken  in  1  branch in EX resolved taken
- dmem_req  in  1  MEM stage holds a load/store needing memory (level)
- dmem_ready  in  1  memory completes the current access this cycle
- cnt_clr  in  1  synchronous clear of both counters
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_write  out  1  ID/EX register enable
- id_ex_flush  out  1  load bubble (all controls 0) into ID/EX
- ex_mem_write  out  1  EX/MEM register enable
- mem_wb_flush  out  1  load bubble into MEM/WB
- mem_err  out  1  sticky timeout error
- stall_cnt  out  CNT_W  cycles in which pc_write=0 while in RUN or MEM_WAIT
- flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Clocking and reset: one clock domain (clk); reset is asynchronous and active-low on rst_n.
- States: BOOT, RUN, MEM_WAIT, ERROR. The state is registered. All strobe outputs are combinational from the state and the inputs.
- Reset values: state=BOOT, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
  - While rst_n=0: all *_write=0, if_id_flush=1, id_ex_flush=1, mem_wb_flush=1.
- BOOT (exactly 1 cycle after reset release):
  - all *_write=0; all flushes=1;
  - next state RUN.
- RUN, evaluated in this priority order:
  1. dmem_req=1 and dmem_ready=0 (freeze):
     - pc_write, if_id_write, id_ex_write and ex_mem_write all 0; mem_wb_flush=1;
     - branch_taken and load_use_stall are ignored this cycle;
     - next state MEM_WAIT; wait_cnt<=1.
  2. branch_taken=1:
     - pc_write=1, if_id_flush=1, id_ex_flush=1, other writes 1;
     - flush_cnt increments;
     - load_use_stall is ignored (the instruction in ID is flushed).
  3. load_use_stall=1:
     - pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1;
     - stall_cnt increments.
  4. Otherwise: all writes 1, all flushes 0.
  - dmem_req=1 with dmem_ready=1 in the same cycle is a zero-wait access: no freeze.
- MEM_WAIT:
  - Outputs are the same as a RUN freeze; stall_cnt increments each cycle.
  - dmem_ready=1: this is the release cycle.
    - Outputs are evaluated as RUN rules 2–4 using the current inputs, so a held branch_taken or load_use_stall takes effect now.
    - Next state RUN; wait_cnt<=0.
  - Else, if MEM_TIMEOUT≠0 and wait_cnt==MEM_TIMEOUT:
    - next state ERROR; mem_err<=1.
  - Else wait_cnt increments.
- ERROR:
  - Full freeze: all writes 0, all flushes 1.
  - mem_err stays 1. Exit is by reset only; all inputs are ignored.
- dmem_req dropping to 0 in MEM_WAIT without dmem_ready is a protocol violation. It is treated as ready (release), and a simulation assertion fires.
- Counters:
  - saturate at 2^CNT_W−1; do not wrap;
  - cnt_clr has priority over an increment in the same cycle.
- Reset asserted mid-MEM_WAIT: wait_cnt is cleared, and the controller re-enters BOOT on release.

Decomposition:
- Package pipe_ctrl_pkg: state enum (BOOT=2'd0, RUN=2'd1, MEM_WAIT=2'd2, ERROR=2'd3) and the default MEM_TIMEOUT constant.
- One sub-module, sat_counter (width parameter; inc and clr inputs), instantiated twice.

Test Plan:
- Reset release, idle inputs: cycle 0 BOOT (pc_write=0, all flushes 1); cycle 1 all writes 1, flushes 0; counters 0.
- load_use_stall=1 for 1 cycle: pc_write=0, if_id_write=0, id_ex_flush=1; next cycle normal; stall_cnt=1.
- branch_taken=1 and load_use_stall=1 together: if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt=1; stall_cnt=0.
- dmem_req=1 with dmem_ready arriving 3 cycles later, branch_taken held during the wait:
  - 3 freeze cycles with mem_wb_flush=1;
  - release cycle shows the branch flush;
  - stall_cnt=3, flush_cnt=1.
- MEM_TIMEOUT=4, dmem_req held with dmem_ready=0: mem_err=1 after the 5th wait cycle; stays frozen; cleared only by rst_n.
- CNT_W=4, load_use_stall held 20 cycles then cnt_clr=1: stall_cnt saturates at 15, then reads 0 on the next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, strobe bundle and defaults for the pipeline stall controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    localparam int MEM_TIMEOUT_DEFAULT = 16;
    localparam int CNT_W_DEFAULT       = 16;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_flush;
    } strobes_t;

    localparam strobes_t STB_FLUSH_ALL = 7'b0010101;
    localparam strobes_t STB_FREEZE    = 7'b0000001;
    localparam strobes_t STB_NORMAL    = 7'b1101010;
    localparam strobes_t STB_BRANCH    = 7'b1111110;
    localparam strobes_t STB_LOAD_USE  = 7'b0001110;

    // A taken branch flushes the ID instruction, which makes any load-use stall moot.
    function automatic strobes_t run_strobes(input logic branch, input logic load_use);
        if (branch) begin
            return STB_BRANCH;
        end else if (load_use) begin
            return STB_LOAD_USE;
        end
        return STB_NORMAL;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// rtl/pipeline_stall_controller_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - merges load-use, branch and memory-wait hazards into per-stage strobes
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    strobes_t          stb;
    logic              flush_inc;
    logic              stall_inc;
    logic              mem_release;

    // A dropped request without ready is released like a normal completion.
    assign mem_release = dmem_ready || !dmem_req;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        stb        = STB_FLUSH_ALL;
        flush_inc  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    stb        = STB_FREEZE;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    stb       = run_strobes(branch_taken, load_use_stall);
                    flush_inc = branch_taken;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_release) begin
                    stb        = run_strobes(branch_taken, load_use_stall);
                    flush_inc  = branch_taken;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    stb = STB_FREEZE;
                    if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT))) begin
                        state_d   = ST_ERROR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                stb = STB_FLUSH_ALL;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        if (!rst_n) begin
            stb = STB_FLUSH_ALL;
        end
    end

    assign stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !stb.pc_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (cnt_clr),
        .count (flush_cnt)
    );

    assign pc_write     = stb.pc_write;
    assign if_id_write  = stb.if_id_write;
    assign if_id_flush  = stb.if_id_flush;
    assign id_ex_write  = stb.id_ex_write;
    assign id_ex_flush  = stb.id_ex_flush;
    assign ex_mem_write = stb.ex_mem_write;
    assign mem_wb_flush = stb.mem_wb_flush;
    assign mem_err      = mem_err_q;

`ifndef SYNTHESIS
    mem_req_dropped_a : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_MEM_WAIT) |-> (dmem_req || dmem_ready));
`endif

endmodule
